// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame length, scheduler states
// and the round-robin pick used to share the TX shift register.
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_STOP = 3'd3,
    ST_DONE = 3'd4
  } sched_state_t;

  // A lone requester always wins; on a tie the one not served last time wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last_grant);
    logic pick;
    if (r0 && r1) begin
      pick = ~last_grant;
    end else if (r1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte-source handshakes plus the shift-register control lines of the UART TX
// scheduler; the scheduler takes the slave side.
interface uart_tx_scheduler_if;

  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       signal_load;
  logic       signal_shift;
  logic [7:0] data_out;
  logic       signal_busy;
  logic       tx_done;
  logic       grant_id;

  modport master (
    output req0, data0, req1, data1, signal_busy,
    input  ack0, ack1, signal_load, signal_shift, data_out, tx_done, grant_id
  );

  modport slave (
    input  req0, data0, req1, data1, signal_busy,
    output ack0, ack1, signal_load, signal_shift, data_out, tx_done, grant_id
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, wraps, and flags
// the cycles where the count sits at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          BCLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Clear has priority over counting; the count holds while disabled.
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign tick = (cnt_r == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX shift register between two byte sources: round-robin grant,
// then load, paced shifts and a full stop-bit period before reporting tx_done.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              BCLK,
  input  logic              RST_N,
  uart_tx_scheduler_if.slave bus
);

  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    LAST_SHIFT = 4'(FRAME_BITS - 1);

  sched_state_t  state_r, state_s;
  logic          grant_r, last_grant_r;
  logic [7:0]    data_out_r;
  logic          ack0_r, ack1_r, load_r, shift_r, done_r;
  logic [3:0]    shift_cnt_r;
  logic          clr_s, en_s, tick_s, pick_s, load_entry_s, shift_s;
  logic [CW-1:0] baud_cnt_s;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT), .CW(CW)) u_baud (
    .BCLK  (BCLK),
    .RST_N (RST_N),
    .clr   (clr_s),
    .en    (en_s),
    .cnt   (baud_cnt_s),
    .tick  (tick_s)
  );

  // Next-state and bit-counter control; STOP parks the counter one short of a
  // full period so the decision cycle completes the stop bit.
  always_comb begin
    state_s = state_r;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        clr_s   = 1'b1;
        state_s = ST_SEND;
      end
      ST_SEND: begin
        if (tick_s && (shift_cnt_r == LAST_SHIFT)) begin
          clr_s   = 1'b1;
          state_s = ST_STOP;
        end else begin
          en_s = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_cnt_s != STOP_LAST) begin
          en_s = 1'b1;
        end else if (!bus.signal_busy) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign pick_s       = rr_pick(bus.req0, bus.req1, last_grant_r);
  assign load_entry_s = (state_r == ST_IDLE) && (state_s == ST_LOAD);
  // Outputs are registered, so a shift is flagged one cycle before the count hits zero.
  assign shift_s      = (state_s == ST_SEND) &&
                        ((state_r == ST_LOAD) || (baud_cnt_s == CNT_LAST));

  // State, grant bookkeeping and registered output pulses.
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      data_out_r   <= 8'h00;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      load_r       <= 1'b0;
      shift_r      <= 1'b0;
      done_r       <= 1'b0;
      shift_cnt_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      load_r  <= load_entry_s;
      ack0_r  <= load_entry_s && !pick_s;
      ack1_r  <= load_entry_s && pick_s;
      shift_r <= shift_s;
      done_r  <= (state_s == ST_DONE);
      if (load_entry_s) begin
        grant_r    <= pick_s;
        data_out_r <= pick_s ? bus.data1 : bus.data0;
      end
      if (state_r == ST_LOAD) begin
        last_grant_r <= grant_r;
        shift_cnt_r  <= 4'd0;
      end else if (shift_r) begin
        shift_cnt_r <= shift_cnt_r + 4'd1;
      end
    end
  end

  assign bus.ack0         = ack0_r;
  assign bus.ack1         = ack1_r;
  assign bus.signal_load  = load_r;
  assign bus.signal_shift = shift_r;
  assign bus.data_out     = data_out_r;
  assign bus.tx_done      = done_r;
  assign bus.grant_id     = grant_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CLKS_PER_BIT=4 and a small
// behavioural model of the TX shift register's busy flag and framing.
module tb_uart_tx_scheduler;

  localparam int C = 4;

  logic BCLK  = 1'b0;
  logic RST_N = 1'b0;

  uart_tx_scheduler_if bus();

  uart_tx_scheduler #(.CLKS_PER_BIT(C)) dut (
    .BCLK  (BCLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 BCLK = ~BCLK;

  int errors = 0, checks = 0, cyc = 0, age = -1, extra_busy = 0;
  int load_cyc = 0, done_cyc = 0, prev_load = 0, shifts = 0, spacing_bad = 0;
  int stray = 0, any_pulse = 0, done_total = 0;
  logic seen_load = 1'b0, seen_done = 1'b0, in_frame = 1'b0;
  logic load_grant = 1'b0, load_ack0 = 1'b0, load_ack1 = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [9:0] frame_sr = 10'h000, bits = 10'h000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive busy for this cycle, then record the DUT's pulses.
  task automatic tick();
    @(posedge BCLK);
    #1;
    cyc++;
    if (age >= 0) age++;
    bus.signal_busy = (age >= 1) && (age <= 10*C - 1 + extra_busy);
    if (bus.signal_load || bus.signal_shift || bus.ack0 || bus.ack1 || bus.tx_done) any_pulse++;
    if ((bus.ack0 || bus.ack1) && !bus.signal_load) stray++;
    if (bus.signal_load) begin
      if (in_frame || !(bus.ack0 ^ bus.ack1)) stray++;
      seen_load   = 1'b1;
      in_frame    = 1'b1;
      load_cyc    = cyc;
      age         = 0;
      load_grant  = bus.grant_id;
      load_ack0   = bus.ack0;
      load_ack1   = bus.ack1;
      load_data   = bus.data_out;
      frame_sr    = {1'b1, bus.data_out, 1'b0};
      bits        = 10'h000;
      shifts      = 0;
      spacing_bad = 0;
    end
    if (bus.signal_shift) begin
      if (!in_frame) stray++;
      if (cyc != load_cyc + 1 + C*shifts) spacing_bad++;
      if (shifts < 10) bits[shifts] = frame_sr[shifts];
      shifts++;
    end
    if (bus.tx_done) begin
      if (!in_frame) stray++;
      seen_done = 1'b1;
      in_frame  = 1'b0;
      done_cyc  = cyc;
      done_total++;
    end
  endtask

  task automatic run_frame(input logic eg, input logic [7:0] ed, input int exp_load);
    int n;
    seen_load = 1'b0;
    n = 0;
    while (!seen_load && n < 200) begin tick(); n++; end
    check("load_seen", seen_load, 1'b1);
    check("load_cycle", load_cyc, exp_load);
    check("grant_id", load_grant, eg);
    check("data_out", load_data, ed);
    check("ack0", load_ack0, !eg);
    check("ack1", load_ack1, eg);
    seen_done = 1'b0;
    n = 0;
    while (!seen_done && n < 200) begin tick(); n++; end
    check("done_seen", seen_done, 1'b1);
    check("done_latency", done_cyc - load_cyc, 10*C + 1 + extra_busy);
    check("shift_count", shifts, 10);
    check("shift_spacing", spacing_bad, 0);
    check("frame_bits", bits, {1'b1, ed, 1'b0});
  endtask

  initial begin
    int n, done_before;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = 8'h00; bus.data1 = 8'h00;
    bus.signal_busy = 1'b0;

    repeat (3) @(posedge BCLK);
    #1;
    check("rst_load", bus.signal_load, 1'b0);
    check("rst_shift", bus.signal_shift, 1'b0);
    check("rst_ack0", bus.ack0, 1'b0);
    check("rst_ack1", bus.ack1, 1'b0);
    check("rst_done", bus.tx_done, 1'b0);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_grant", bus.grant_id, 1'b0);
    RST_N = 1'b1;

    any_pulse = 0;
    repeat (100) tick();
    check("idle_no_pulses", any_pulse, 0);

    bus.data0 = 8'hA5; bus.req0 = 1'b1;
    run_frame(1'b0, 8'hA5, cyc + 1);
    check("a5_line_bits", bits, 10'h34A);

    // Both held: requester 0 was served last, so 1 wins the first tie.
    bus.data0 = 8'h3C; bus.data1 = 8'hC3; bus.req0 = 1'b1; bus.req1 = 1'b1;
    run_frame(1'b1, 8'hC3, done_cyc + 2);
    run_frame(1'b0, 8'h3C, done_cyc + 2);
    run_frame(1'b1, 8'hC3, done_cyc + 2);
    run_frame(1'b0, 8'h3C, done_cyc + 2);

    bus.req0 = 1'b0; bus.data1 = 8'h5A;
    run_frame(1'b1, 8'h5A, done_cyc + 2);
    prev_load = load_cyc;
    run_frame(1'b1, 8'h5A, done_cyc + 2);
    check("req1_spacing_a", load_cyc - prev_load, 43);
    prev_load = load_cyc;
    run_frame(1'b1, 8'h5A, done_cyc + 2);
    check("req1_spacing_b", load_cyc - prev_load, 43);
    bus.req1 = 1'b0;

    repeat (3) tick();
    extra_busy = 6; bus.data0 = 8'h0F; bus.req0 = 1'b1;
    run_frame(1'b0, 8'h0F, cyc + 1);
    check("busy_hold_latency", done_cyc - load_cyc, 47);
    bus.req0 = 1'b0; extra_busy = 0;

    repeat (2) tick();
    bus.data0 = 8'h81; bus.req0 = 1'b1;
    seen_load = 1'b0;
    n = 0;
    while (!seen_load && n < 20) begin tick(); n++; end
    check("abort_load_seen", seen_load, 1'b1);
    n = 0;
    while (shifts < 6 && n < 100) begin tick(); n++; end
    check("abort_at_bit4", shifts, 6);
    done_before = done_total;
    RST_N = 1'b0;
    #1;
    check("abort_load", bus.signal_load, 1'b0);
    check("abort_shift", bus.signal_shift, 1'b0);
    check("abort_ack0", bus.ack0, 1'b0);
    check("abort_ack1", bus.ack1, 1'b0);
    check("abort_done", bus.tx_done, 1'b0);
    check("abort_data_out", bus.data_out, 8'h00);
    check("abort_grant", bus.grant_id, 1'b0);
    in_frame = 1'b0; age = -1; bus.signal_busy = 1'b0;
    repeat (3) tick();
    check("abort_no_done", done_total, done_before);
    RST_N = 1'b1;
    run_frame(1'b0, 8'h81, cyc + 1);
    check("rerun_one_done", done_total, done_before + 1);
    bus.req0 = 1'b0;
    repeat (5) tick();
    check("no_stray_pulses", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
